// File: rtl/sdram_load_sequencer_pkg.sv
// Shared types and constants for the SDRAM load sequencer and its loader.
package sdram_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_IMG,
    S_WAIT_IMG,
    S_REQ_COEF,
    S_WAIT_COEF,
    S_COMPUTE,
    S_FINISH,
    S_ERROR
  } seq_state_e;

  // Callers slice this down to their own select width.
  localparam logic [31:0] IMAGE_SEL = 32'hFFFF_FFFF;

  // Buffer sizes the loader uses for one image and one layer of coefficients.
  localparam int IMG_WORDS  = 4096;
  localparam int COEF_WORDS = 1024;

  // States in which the watchdog is allowed to count.
  function automatic logic is_bounded_state(input seq_state_e s);
    return (s == S_REQ_IMG) || (s == S_WAIT_IMG) ||
           (s == S_REQ_COEF) || (s == S_WAIT_COEF);
  endfunction

endpackage

// File: rtl/sdram_load_sequencer_if.sv
// Loader request handshake. get_data is held until busy rises; the returned data
// is valid once busy falls again, and get_data must already be low by then.
interface sdram_load_sequencer_if #(
  parameter int NUMLAYERS = 2
);
  logic                 get_data;
  logic [NUMLAYERS-1:0] which_data;
  logic                 busy;

  modport master (output get_data, output which_data, input busy);
  modport slave  (input get_data, input which_data, output busy);
endinterface

// File: rtl/sdram_load_sequencer_watchdog.sv
// Cycle counter that flags when a request/wait state has lasted TIMEOUT cycles.
module seq_watchdog #(
  parameter int TIMEOUT = 4096,
  parameter int TBITS   = 13
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TBITS-1:0] count_q;
  logic [TBITS-1:0] count_d;

  assign expired = (count_q == TBITS'(TIMEOUT));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdram_load_sequencer.sv
// Run-level sequencer: loads the image, then per layer loads coefficients,
// starts the compute engine and waits for it to finish.
module sdram_load_sequencer
  import sdram_seq_pkg::*;
#(
  parameter int NUMLAYERS   = 2,
  parameter int LAYER_COUNT = 3,
  parameter int TIMEOUT     = 4096,
  parameter int TBITS       = 13
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  sdram_load_sequencer_if.master        ld,
  output logic                          layer_start,
  output logic [NUMLAYERS-1:0]          layer_idx,
  input  logic                          layer_done,
  output logic                          image_ready,
  output logic                          run_busy,
  output logic                          done,
  output logic                          error,
  output seq_state_e                    dbg_state
);

  localparam logic [NUMLAYERS-1:0] LAST_LAYER = NUMLAYERS'(LAYER_COUNT - 1);
  localparam logic [NUMLAYERS-1:0] IMG_SEL    = IMAGE_SEL[NUMLAYERS-1:0];

  seq_state_e           state_q, state_d;
  logic [NUMLAYERS-1:0] cnt_q, cnt_d;
  logic                 layer_start_q, layer_start_d;
  logic                 image_ready_q, image_ready_d;
  logic                 error_q, error_d;
  logic                 wd_expired;

  seq_watchdog #(.TIMEOUT(TIMEOUT), .TBITS(TBITS)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .enable  (is_bounded_state(state_q)),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    layer_start_d = 1'b0;
    image_ready_d = image_ready_q;
    error_d       = error_q;
    if (abort) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      image_ready_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_d       = S_REQ_IMG;
            cnt_d         = '0;
            error_d       = 1'b0;
            image_ready_d = 1'b0;
          end
        end
        S_REQ_IMG, S_REQ_COEF: begin
          // Moving on as soon as busy is seen drops get_data before busy can fall.
          if (wd_expired) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (ld.busy) begin
            state_d = (state_q == S_REQ_IMG) ? S_WAIT_IMG : S_WAIT_COEF;
          end
        end
        S_WAIT_IMG: begin
          if (wd_expired) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (!ld.busy) begin
            state_d       = S_REQ_COEF;
            cnt_d         = '0;
            image_ready_d = 1'b1;
          end
        end
        S_WAIT_COEF: begin
          if (wd_expired) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (!ld.busy) begin
            state_d       = S_COMPUTE;
            layer_start_d = 1'b1;
          end
        end
        S_COMPUTE: begin
          if (layer_done) begin
            if (cnt_q == LAST_LAYER) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_REQ_COEF;
              cnt_d   = cnt_q + 1'b1;
            end
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      layer_start_q <= 1'b0;
      image_ready_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      layer_start_q <= layer_start_d;
      image_ready_q <= image_ready_d;
      error_q       <= error_d;
    end
  end

  assign ld.get_data   = (state_q == S_REQ_IMG) || (state_q == S_REQ_COEF);
  assign ld.which_data = ((state_q == S_REQ_IMG) || (state_q == S_WAIT_IMG)) ? IMG_SEL : cnt_q;
  assign layer_start   = layer_start_q;
  assign layer_idx     = cnt_q;
  assign image_ready   = image_ready_q;
  assign run_busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign done          = (state_q == S_FINISH);
  assign error         = error_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/sdram_load_sequencer.md
Name: sdram_load_sequencer

Overview:
- Run-level controller for the SDRAM data loader (get_data/which_data/busy handshake).
- On one start pulse it fetches the image, then for each network layer fetches that layer's coefficients, hands them to the compute engine and waits for it to finish.
- Coefficients are fetched per layer because the loader's coefficient buffer is shared by all layers.
- Sits between the top-level run control and the loader; it is the only driver of the loader's request inputs.

Parameters:
- NUMLAYERS, 2, width of which_data and layer_idx.
- LAYER_COUNT, 3, number of network layers sequenced per run. Legal range is 1 .. 2**NUMLAYERS-1.
- TIMEOUT, 4096, maximum cycles spent in any request or wait state before error.
- TBITS, 13, watchdog counter width. Must satisfy 2**TBITS > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE
- abort  in  1  synchronous abort; returns the block to IDLE from any state
- get_data  out  1  load request to the loader
- which_data  out  NUMLAYERS  load select: layer index l = l; image = all ones
- busy  in  1  loader busy flag; load data is valid once it falls
- layer_start  out  1  one-cycle pulse: coefficients for layer_idx are valid
- layer_idx  out  NUMLAYERS  layer currently loaded or computing
- layer_done  in  1  compute engine finished layer_idx
- image_ready  out  1  image buffer valid; high from the end of the image load until the next start or abort
- run_busy  out  1  high in every state except IDLE and ERROR
- done  out  1  one-cycle pulse when the last layer completes
- error  out  1  sticky watchdog flag; cleared by the next accepted start

Behaviour:
- Reset: every output is 0, state is IDLE, layer counter is 0, watchdog is 0.
- States: IDLE, REQ_IMG, WAIT_IMG, REQ_COEF, WAIT_COEF, COMPUTE, FINISH, ERROR.
- IDLE
  - start=1 → REQ_IMG; error clears and image_ready clears.
  - Register start at edge N → get_data=1 and which_data=all-ones in cycle N+1.
- REQ_IMG / REQ_COEF
  - get_data=1 throughout. which_data = all ones for the image, or the layer counter for coefficients.
  - Leave on the first cycle busy=1 (loader acknowledged) → WAIT_IMG / WAIT_COEF.
  - get_data deasserts in the next cycle. The loader must never see get_data high after its busy falls, or it would reload.
- WAIT_IMG / WAIT_COEF
  - get_data=0; leave when busy=0.
  - From WAIT_IMG: → REQ_COEF with layer counter 0; image_ready=1.
  - From WAIT_COEF: → COMPUTE; layer_start pulses for exactly one cycle, in the first COMPUTE cycle.
- COMPUTE
  - Waits for layer_done=1 (sampled only in this state).
  - If the counter is not the last layer: counter+1 → REQ_COEF.
  - Else → FINISH.
  - layer_idx follows the counter continuously.
- FINISH: done=1 for one cycle → IDLE. image_ready stays high.
- Watchdog
  - Clears on every state change.
  - Increments in REQ_* and WAIT_* only; COMPUTE is unbounded.
  - Reaching TIMEOUT → ERROR, with error=1 and get_data=0.
- ERROR: stays until start (treated as in IDLE) or abort (→ IDLE, error stays set).
- abort
  - Highest priority in every state → IDLE next cycle.
  - get_data, layer_start and image_ready all go to 0; counter clears.
  - start and abort in the same cycle: abort wins and no run begins.
- Ignored inputs:
  - start while run_busy=1.
  - layer_done outside COMPUTE.
  - busy in IDLE, COMPUTE and FINISH.
- Reset mid-run: immediate return to reset values. The loader is not notified; it completes its current transfer on its own.
- Layer counter: NUMLAYERS bits. Last layer = LAYER_COUNT-1, so the counter never wraps.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.

Decomposition:
- Package sdram_seq_pkg holds:
  - the state enum type;
  - the IMAGE_SEL all-ones select constant;
  - the layer-size localparams shared with the loader.
- One natural sub-module, seq_watchdog:
  - inputs clear and enable;
  - output expired when count == TIMEOUT;
  - same clock and reset as the parent.

Test Plan:
- Full run, LAYER_COUNT=3, responsive loader (busy high 2 cycles after get_data, held 10 cycles), layer_done 5 cycles after each layer_start → which_data sequence 3,0,1,2; three layer_start pulses with layer_idx 0,1,2; one done pulse; get_data never high while busy is low after an acknowledge.
- Loader never asserts busy, TIMEOUT=16 → error=1 and get_data=0 after 16 cycles in REQ_IMG; a following start clears error and begins REQ_IMG.
- abort during WAIT_COEF with layer 1 loading → IDLE next cycle, image_ready=0, run_busy=0, no further layer_start or done.
- start pulsed during COMPUTE, and layer_done pulsed during REQ_COEF → both ignored; sequence and counts are identical to the first scenario.
- start and abort in the same cycle in IDLE → stays IDLE, get_data stays 0.
- reset_n low mid-COMPUTE → all outputs 0 asynchronously; after release, start produces which_data=3 with get_data=1 one cycle later.
